// File: rtl/regbus_read_sequencer.sv
// Pipelined read sequencer for a shared tri-state register read bus: one-hot drive, capture, 2-entry response FIFO.
// Optional write-back bypass of the captured data is enabled by defining REGBUS_WB_BYPASS_EN.
module regbus_read_sequencer #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic [NUM_REGS-1:0] rd_oe,
  input  logic [DATA_W-1:0]   bus_in,
`ifdef REGBUS_WB_BYPASS_EN
  input  logic                wb_we,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [ADDR_W-1:0]   rsp_addr,
  output logic                rsp_err,
  output logic                busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRIVE = 1'b1;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic [0:0]          state_q, state_d;
  logic [ADDR_W-1:0]   drv_addr_q, drv_addr_d;
  logic [NUM_REGS-1:0] rd_oe_d;
  logic                drive_active;
  logic                accept;
  logic                push;
  logic                pop;
  logic                in_range;
  logic [CNT_W-1:0]    count_q;
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  rsp_t                mem_q [DEPTH];
  rsp_t                push_entry;
  rsp_t                head;

  assign drive_active = (state_q == S_DRIVE);
  // Credits cover both FIFO entries and the capture still in flight, so a push always has room.
  assign req_ready    = clr && ((count_q + {1'b0, drive_active}) < CNT_W'(2));
  assign accept       = req_valid && req_ready;
  assign push         = drive_active;
  assign pop          = rsp_valid && rsp_ready;
  assign in_range     = 32'(drv_addr_q) < NUM_REGS;

  // FSM state and drive registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= S_IDLE;
      drv_addr_q <= '0;
      rd_oe      <= '0;
    end else begin
      state_q    <= state_d;
      drv_addr_q <= drv_addr_d;
      rd_oe      <= rd_oe_d;
    end
  end

  // Next state and one-hot enable decode; register 0 and out-of-range addresses never drive the bus
  always_comb begin
    state_d    = S_IDLE;
    drv_addr_d = drv_addr_q;
    rd_oe_d    = '0;
    case (state_q)
      S_IDLE, S_DRIVE: begin
        if (accept) begin
          state_d    = S_DRIVE;
          drv_addr_d = req_addr;
          for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (req_addr == ADDR_W'(i)) rd_oe_d[i] = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response captured at the end of the drive cycle
  always_comb begin
    push_entry      = '0;
    push_entry.addr = drv_addr_q;
    if (!in_range) begin
      push_entry.err = 1'b1;
    end else if (drv_addr_q != '0) begin
      push_entry.data = bus_in;
`ifdef REGBUS_WB_BYPASS_EN
      if (wb_we && (wb_addr == drv_addr_q)) push_entry.data = wb_data;
`endif
    end
  end

  // Two-entry response FIFO
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign rsp_valid = (count_q != '0);
  assign rsp_data  = head.data;
  assign rsp_addr  = head.addr;
  assign rsp_err   = head.err;
  assign busy      = drive_active || (count_q != '0);

endmodule

// File: tb/tb_regbus_read_sequencer.sv
// Bench for regbus_read_sequencer: directed vector table, multi-cycle corner sequences and
// randomized traffic checked every cycle against a queue-based transaction model.
module tb_regbus_read_sequencer;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;

  logic                clk = 1'b0;
  logic                clr = 1'b0;
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic [NUM_REGS-1:0] rd_oe;
  logic [DATA_W-1:0]   bus_in;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic [ADDR_W-1:0]   rsp_addr;
  logic                rsp_err;
  logic                busy;
`ifdef REGBUS_WB_BYPASS_EN
  logic                wb_we;
  logic [ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;
`endif

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] bus_idle;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Register bank: the enabled register drives the bus, otherwise it floats to bus_idle
  always_comb begin
    bus_in = bus_idle;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (rd_oe[i]) bus_in = regs[i];
    end
  end

  regbus_read_sequencer #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rd_oe(rd_oe), .bus_in(bus_in),
`ifdef REGBUS_WB_BYPASS_EN
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err), .busy(busy)
  );

  // Transaction model: outstanding reads are the in-flight request plus queued responses
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t              rspq[$];
  bit                infl = 1'b0;
  logic [ADDR_W-1:0] infl_addr = '0;
  bit                m_acc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (rspq.size() + (infl ? 1 : 0)) < 2;
  endfunction

  task automatic model_reset();
    rspq.delete();
    infl      = 1'b0;
    infl_addr = '0;
    m_acc     = 1'b0;
  endtask

  task automatic check_outputs();
    logic [NUM_REGS-1:0] exp_oe;
    exp_oe = '0;
    if (infl && infl_addr != '0 && int'(infl_addr) < int'(NUM_REGS)) exp_oe[infl_addr] = 1'b1;
    chk("req_ready", req_ready, m_ready());
    chk("rd_oe", rd_oe, exp_oe);
    chk("rsp_valid", rsp_valid, rspq.size() != 0);
    if (rspq.size() != 0) begin
      chk("rsp_data", rsp_data, rspq[0].data);
      chk("rsp_addr", rsp_addr, rspq[0].addr);
      chk("rsp_err", rsp_err, rspq[0].err);
    end
    chk("busy", busy, infl || rspq.size() != 0);
  endtask

  task automatic model_update();
    exp_t e;
    m_acc = req_valid && m_ready();
    if (rspq.size() != 0 && rsp_ready) void'(rspq.pop_front());
    if (infl) begin
      e.addr = infl_addr;
      e.err  = int'(infl_addr) >= int'(NUM_REGS);
      e.data = (infl_addr == '0 || e.err) ? '0 : regs[infl_addr];
`ifdef REGBUS_WB_BYPASS_EN
      if (wb_we && wb_addr == infl_addr && infl_addr != '0 && !e.err) e.data = wb_data;
`endif
      rspq.push_back(e);
    end
    infl      = m_acc;
    infl_addr = req_addr;
  endtask

  // Advance one cycle with the inputs currently applied, then check at the falling edge
  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    repeat (4) tick();
  endtask

  typedef struct {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   bus;
    logic [DATA_W-1:0]   exp_data;
    logic [NUM_REGS-1:0] exp_oe;
  } vec_t;

  vec_t vt[4];

  initial begin
    int k;
    int nxt;
    int acc;
    int cyc;
    logic [DATA_W-1:0] held;
    logic [DATA_W-1:0] exp_byp;

    vt[0] = '{addr: 5'd5,  bus: 32'hDEADBEEF, exp_data: 32'hDEADBEEF, exp_oe: 32'h0000_0020};
    vt[1] = '{addr: 5'd0,  bus: 32'hFFFFFFFF, exp_data: 32'h0,        exp_oe: 32'h0};
    vt[2] = '{addr: 5'd31, bus: 32'h0BADF00D, exp_data: 32'h0BADF00D, exp_oe: 32'h8000_0000};
    vt[3] = '{addr: 5'd1,  bus: 32'h00000001, exp_data: 32'h00000001, exp_oe: 32'h0000_0002};

    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    bus_idle  = 32'hA5A5_5A5A;
`ifdef REGBUS_WB_BYPASS_EN
    wb_we   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
`endif
    for (int i = 0; i < int'(NUM_REGS); i++) regs[i] = $urandom;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_rd_oe", rd_oe, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    clr = 1'b1;
    #1;
    model_reset();
    check_outputs();

    // Directed single reads from the vector table
    for (int v = 0; v < 4; v++) begin
      rsp_ready         = 1'b0;
      regs[vt[v].addr]  = vt[v].bus;
      bus_idle          = vt[v].bus;
      req_valid         = 1'b1;
      req_addr          = vt[v].addr;
      chk("vec_req_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      chk("vec_rd_oe_c1", rd_oe, vt[v].exp_oe);
      chk("vec_no_rsp_c1", rsp_valid, 0);
      tick();
      chk("vec_rd_oe_c2", rd_oe, 0);
      chk("vec_rsp_valid", rsp_valid, 1);
      chk("vec_rsp_data", rsp_data, vt[v].exp_data);
      chk("vec_rsp_addr", rsp_addr, vt[v].addr);
      chk("vec_rsp_err", rsp_err, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("vec_empty", rsp_valid, 0);
      chk("vec_idle", busy, 0);
    end
    bus_idle = 32'hA5A5_5A5A;

    // Stream of addresses 1..4 with the consumer always ready: in-order responses
    rsp_ready = 1'b1;
    k         = 1;
    nxt       = 1;
    req_valid = 1'b1;
    req_addr  = ADDR_W'(k);
    for (int c = 0; c < 40 && nxt < 5; c++) begin
      tick();
      if (m_acc) begin
        k++;
        if (k > 4) req_valid = 1'b0;
        else req_addr = ADDR_W'(k);
      end
      if (rsp_valid && rsp_ready) begin
        chk("stream_order", rsp_addr, nxt);
        nxt++;
      end
    end
    if (nxt < 5) begin
      fails++;
      $display("FAIL stream_timeout: got %0d responses expected 4", nxt - 1);
    end
    drain();

    // Backpressure: only two reads outstanding, head held stable, third accepted after a pop
    rsp_ready = 1'b0;
    regs[10]  = 32'h1010_1010;
    regs[11]  = 32'h1111_1111;
    regs[12]  = 32'h1212_1212;
    acc       = 0;
    req_valid = 1'b1;
    req_addr  = 5'd10;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (m_acc) begin
        acc++;
        req_addr = ADDR_W'(10 + acc);
      end
    end
    chk("bp_accepted", acc, 2);
    chk("bp_req_ready_low", req_ready, 0);
    held = rsp_data;
    chk("bp_head_data", held, 32'h1010_1010);
    tick();
    chk("bp_head_stable", rsp_data, held);
    rsp_ready = 1'b1;
    cyc       = 0;
    while (acc < 3 && cyc < 10) begin
      tick();
      cyc++;
      if (m_acc) acc++;
    end
    chk("bp_third_after_pop", cyc, 2);
    drain();

    // Reset asserted in the middle of a drive
    regs[7]   = $urandom;
    req_valid = 1'b1;
    req_addr  = 5'd7;
    tick();
    req_valid = 1'b0;
    chk("mid_rst_drive", rd_oe, 32'h0000_0080);
    #2 clr = 1'b0;
    #1;
    chk("mid_rst_oe_async", rd_oe, 0);
    chk("mid_rst_ready", req_ready, 0);
    model_reset();
    repeat (2) @(negedge clk);
    clr = 1'b1;
    #1;
    chk("mid_rst_no_rsp", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    check_outputs();

    // Read of register 9 while a write to it is in progress
    regs[9]  = 32'h0;
    bus_idle = 32'h0;
`ifdef REGBUS_WB_BYPASS_EN
    wb_we   = 1'b1;
    wb_addr = 5'd9;
    wb_data = 32'h12345678;
    exp_byp = 32'h12345678;
`else
    exp_byp = 32'h0;
`endif
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 5'd9;
    tick();
    req_valid = 1'b0;
    tick();
`ifdef REGBUS_WB_BYPASS_EN
    wb_we = 1'b0;
`endif
    chk("wb_rsp_valid", rsp_valid, 1);
    chk("wb_rsp_data", rsp_data, exp_byp);
    drain();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      rsp_ready = ($urandom_range(0, 3) != 0);
      regs[$urandom_range(0, NUM_REGS - 1)] = $urandom;
      bus_idle  = $urandom;
`ifdef REGBUS_WB_BYPASS_EN
      wb_we   = $urandom_range(0, 1) == 1;
      wb_addr = ($urandom_range(0, 1) == 1) ? infl_addr : ADDR_W'($urandom_range(0, NUM_REGS - 1));
      wb_data = $urandom;
`endif
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
